regfile_read_arbiter: RTL and testbench
=======================================

Name: regfile_read_arbiter

Overview:
Shares the single read port of the 64-entry register file among NREQ requesters using round-robin arbitration. A 64-bit write-pending scoreboard blocks reads of any register with an outstanding write. The block drives the register-file read address, which feeds the 6-to-64 read decoder. It captures the read data and returns it to the granted requester one cycle later. It sits between the pipeline's operand-fetch requesters and the register file.

Parameters:
NREQ, 3, number of requesters (2..8)
AW, 6, register index width
DW, 64, data width
NREGS, 64, number of registers (2**AW)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
req_valid  in  NREQ  requester i has a read pending
req_addr  in  NREQ*AW  register index per requester, packed, slice i = [i*AW +: AW]
req_ready  out  NREQ  one-hot grant, combinational; request i is accepted when req_valid[i] & req_ready[i]
rf_rd_en  out  1  high in any cycle with a grant
rf_rd_addr  out  AW  index of the granted request; 0 when there is no grant
rf_rd_data  in  DW  combinational register-file read data for rf_rd_addr
resp_valid  out  NREQ  one-hot, registered; data for the request accepted in the previous cycle
resp_data  out  DW  registered read data
reserve_valid  in  1  marks reserve_addr as write-pending
reserve_addr  in  AW  register about to be written
wb_valid  in  1  writeback complete; clears the pending bit for wb_addr
wb_addr  in  AW  register written back
busy_vec  out  NREGS  scoreboard state, registered

Behaviour:
- Reset values, applied while reset=1 at a clock edge:
  - resp_valid=0, resp_data=0, busy_vec=0, round-robin pointer=0.
  - req_ready and rf_rd_en are forced to 0 combinationally while reset=1.
- Eligibility: request i is eligible iff req_valid[i]=1 and busy_vec[req_addr_i]=0, evaluated on the registered busy_vec.
  - There is no same-cycle bypass from wb_valid; the request becomes eligible the following cycle.
- Arbitration: the first eligible index at or after the pointer wins, searching cyclically.
  - Exactly one req_ready bit is set when any request is eligible; otherwise all are 0.
  - Ineligible requesters wait with ready=0 and hold valid/addr stable (requester obligation).
- Pointer: after a grant to index g, the pointer becomes (g+1) mod NREQ. With no grant, the pointer holds.
- Read path: in grant cycle N, rf_rd_addr = winner's address and rf_rd_en=1.
  - At the edge ending N, resp_data <= rf_rd_data and resp_valid <= onehot(g).
  - Latency is exactly 1 cycle. Throughput is 1 read per cycle.
- No grant in cycle N: resp_valid=0 in N+1 and resp_data holds its previous value.
- Scoreboard, next state per bit: set if reserve_valid & reserve_addr==k; else clear if wb_valid & wb_addr==k; else hold.
  - Reserve and wb to the same register in the same cycle leaves the bit set (reserve wins).
  - Reserve of an already-busy register leaves it busy; only one write is tracked per register.
  - wb to a non-busy register has no effect.
- Read and reserve of the same register in the same cycle: the read is granted (it sees the old bit) and returns the pre-write value. The bit is set from the next cycle.
- Reset mid-operation: a response in flight is dropped (resp_valid=0 the next cycle) and all reservations are cleared.

Decomposition:
- Package regfile_pkg: AW, DW, NREGS constants; reg_id_t = logic [AW-1:0]; data_t = logic [DW-1:0].
- Sub-module rr_arbiter (parameter N): inputs clk, reset, eligible[N]; outputs grant[N] (one-hot), grant_idx. It holds the pointer internally.
- The scoreboard stays inline as a 64-bit register with decoded set/clear masks.

Test Plan:
- Single requester: req0 addr=5, busy=0, rf_rd_data=0xDEAD -> req_ready=001, rf_rd_addr=5 in cycle N; resp_valid=001, resp_data=0xDEAD in N+1.
- Contention: all three valid continuously, pointer=0 -> grants 0,1,2,0 on consecutive cycles; resp_valid follows one cycle later in the same order.
- Scoreboard block: reserve addr=9 at cycle 0, req1 addr=9 from cycle 1 -> no grant; wb addr=9 at cycle 4 -> grant at cycle 5, response at cycle 6.
- Reserve/wb collision: reserve and wb both addr=12 in the same cycle -> busy_vec[12]=1 next cycle; a later wb addr=12 -> busy_vec[12]=0.
- Skip ineligible: busy_vec[3]=1, req0 addr=3, req1 addr=4, pointer=0 -> grant=req1, pointer becomes 2, req0 still waiting.
- Reset mid-flight: grant in cycle N, reset=1 in N+1 -> resp_valid=0, busy_vec=0, pointer=0; with req0 valid after reset, req0 is granted first.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ==========================================================================
// regfile_pkg : register-file geometry and shared types   | rev 1.0
// ==========================================================================
package regfile_pkg;
   localparam int AW    = 6;
   localparam int DW    = 64;
   localparam int NREGS = 2 ** AW;

   typedef logic [AW-1:0] reg_id_t;
   typedef logic [DW-1:0] data_t;
endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ==========================================================================
// rr_arbiter : N-way round-robin arbiter with internal pointer | rev 1.0
// ==========================================================================
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  eligible,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx
);
   logic [IW-1:0] ptr;
   logic          found;
   logic [IW:0]   cand;

   // Cyclic search starting at the pointer; first eligible index wins.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr} + (IW+1)'(k);
         if (cand >= (IW+1)'(N))
            cand = cand - (IW+1)'(N);
         if (!found && eligible[cand[IW-1:0]]) begin
            found                 = 1'b1;
            grant[cand[IW-1:0]]   = 1'b1;
            grant_idx             = cand[IW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         ptr <= '0;
      else if (found)
         ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
   end
endmodule
`default_nettype wire

// File: rtl/regfile_read_arbiter.sv
`default_nettype none
// ==========================================================================
// regfile_read_arbiter : shared RF read port, RR arbitration, write scoreboard
// rev 1.0
// ==========================================================================
module regfile_read_arbiter #(
   parameter int NREQ  = 3,
   parameter int AW    = regfile_pkg::AW,
   parameter int DW    = regfile_pkg::DW,
   parameter int NREGS = regfile_pkg::NREGS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NREQ-1:0]    req_valid,
   input  logic [NREQ*AW-1:0] req_addr,
   output logic [NREQ-1:0]    req_ready,
   output logic               rf_rd_en,
   output logic [AW-1:0]      rf_rd_addr,
   input  logic [DW-1:0]      rf_rd_data,
   output logic [NREQ-1:0]    resp_valid,
   output logic [DW-1:0]      resp_data,
   input  logic               reserve_valid,
   input  logic [AW-1:0]      reserve_addr,
   input  logic               wb_valid,
   input  logic [AW-1:0]      wb_addr,
   output logic [NREGS-1:0]   busy_vec
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]  eligible;
   logic [NREQ-1:0]  grant;
   logic [IW-1:0]    grant_idx;
   logic [NREGS-1:0] set_mask;
   logic [NREGS-1:0] clr_mask;

   // Eligibility uses the registered scoreboard only: no writeback bypass.
   for (genvar i = 0; i < NREQ; i++) begin : g_elig
      assign eligible[i] = req_valid[i] & ~busy_vec[req_addr[i*AW +: AW]] & ~reset;
   end

   rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .eligible  (eligible),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   assign req_ready  = grant;
   assign rf_rd_en   = |grant;
   assign rf_rd_addr = rf_rd_en ? req_addr[int'(grant_idx)*AW +: AW] : '0;

   assign set_mask = reserve_valid ? (NREGS'(1) << reserve_addr) : '0;
   assign clr_mask = wb_valid      ? (NREGS'(1) << wb_addr)      : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_vec   <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
      end else begin
         // Reserve wins over a same-cycle writeback to the same register.
         busy_vec   <= set_mask | (busy_vec & ~clr_mask);
         resp_valid <= grant;
         if (rf_rd_en)
            resp_data <= rf_rd_data;
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_regfile_read_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_regfile_read_arbiter : directed self-checking bench       | rev 1.0
// ==========================================================================
module tb_regfile_read_arbiter;
   import regfile_pkg::*;

   localparam int NREQ = 3;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ-1:0]    req_ready;
   logic               rf_rd_en;
   reg_id_t            rf_rd_addr;
   data_t              rf_rd_data;
   logic [NREQ-1:0]    resp_valid;
   data_t              resp_data;
   logic               reserve_valid;
   reg_id_t            reserve_addr;
   logic               wb_valid;
   reg_id_t            wb_addr;
   logic [NREGS-1:0]   busy_vec;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_read_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .NREGS(NREGS)) dut (
      .clk           (clk),
      .reset         (reset),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_ready     (req_ready),
      .rf_rd_en      (rf_rd_en),
      .rf_rd_addr    (rf_rd_addr),
      .rf_rd_data    (rf_rd_data),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
      .reserve_valid (reserve_valid),
      .reserve_addr  (reserve_addr),
      .wb_valid      (wb_valid),
      .wb_addr       (wb_addr),
      .busy_vec      (busy_vec)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one edge and settle just after it; inputs then change here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   logic [NREQ-1:0] exp_g [4];

   initial begin
      reset = 1'b1; req_valid = '0; req_addr = '0; rf_rd_data = '0;
      reserve_valid = 1'b0; reserve_addr = '0; wb_valid = 1'b0; wb_addr = '0;
      step(); step();
      req_valid = 3'b111;
      #1;
      check("rst_ready_forced", 64'(req_ready), 64'h0);
      check("rst_rd_en_forced", 64'(rf_rd_en), 64'h0);
      check("rst_resp_valid", 64'(resp_valid), 64'h0);
      check("rst_busy", busy_vec, 64'h0);
      check("rst_resp_data", resp_data, 64'h0);
      req_valid = '0;
      reset = 1'b0;
      step();

      // Single requester
      req_valid = 3'b001; set_addr(0, 6'd5); rf_rd_data = 64'hDEAD;
      #1;
      check("single_ready", 64'(req_ready), 64'h1);
      check("single_rd_addr", 64'(rf_rd_addr), 64'd5);
      check("single_rd_en", 64'(rf_rd_en), 64'h1);
      step();
      req_valid = '0; rf_rd_data = 64'h1111;
      check("single_resp_valid", 64'(resp_valid), 64'h1);
      check("single_resp_data", resp_data, 64'hDEAD);
      #1;
      check("idle_rd_en", 64'(rf_rd_en), 64'h0);
      check("idle_rd_addr", 64'(rf_rd_addr), 64'h0);
      step();
      check("idle_resp_valid", 64'(resp_valid), 64'h0);
      check("idle_resp_hold", resp_data, 64'hDEAD);

      // Reset pulse to bring the pointer back to 0, then full contention
      reset = 1'b1; step(); reset = 1'b0;
      req_valid = 3'b111; set_addr(0, 6'd1); set_addr(1, 6'd2); set_addr(2, 6'd3);
      exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
      for (int c = 0; c < 4; c++) begin
         rf_rd_data = 64'hA0 + 64'(c);
         #1;
         check($sformatf("cont_ready_%0d", c), 64'(req_ready), 64'(exp_g[c]));
         check($sformatf("cont_rd_addr_%0d", c), 64'(rf_rd_addr), 64'(c % 3 + 1));
         step();
         check($sformatf("cont_resp_valid_%0d", c), 64'(resp_valid), 64'(exp_g[c]));
         check($sformatf("cont_resp_data_%0d", c), resp_data, 64'hA0 + 64'(c));
      end
      // pointer is now 1

      // Scoreboard block on register 9
      req_valid = '0;
      reserve_valid = 1'b1; reserve_addr = 6'd9;
      step();
      reserve_valid = 1'b0;
      check("sb_busy9_set", busy_vec, 64'h1 << 9);
      req_valid = 3'b010; set_addr(1, 6'd9);
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("sb_blocked_%0d", c), 64'(req_ready), 64'h0);
         step();
      end
      wb_valid = 1'b1; wb_addr = 6'd9;
      #1;
      check("sb_no_bypass", 64'(req_ready), 64'h0);
      step();
      wb_valid = 1'b0; rf_rd_data = 64'h99;
      check("sb_busy9_clr", busy_vec, 64'h0);
      #1;
      check("sb_grant_ready", 64'(req_ready), 64'h2);
      check("sb_grant_addr", 64'(rf_rd_addr), 64'd9);
      step();
      req_valid = '0;
      check("sb_resp_valid", 64'(resp_valid), 64'h2);
      check("sb_resp_data", resp_data, 64'h99);
      // pointer is now 2

      // Reserve/wb collision on 12, then lone wb clears it
      reserve_valid = 1'b1; reserve_addr = 6'd12; wb_valid = 1'b1; wb_addr = 6'd12;
      step();
      reserve_valid = 1'b0;
      check("coll_busy12_set", busy_vec, 64'h1 << 12);
      step();
      wb_valid = 1'b0;
      check("coll_busy12_clr", busy_vec, 64'h0);
      wb_valid = 1'b1; wb_addr = 6'd20;
      step();
      wb_valid = 1'b0;
      check("wb_nonbusy", busy_vec, 64'h0);
      reserve_valid = 1'b1; reserve_addr = 6'd30;
      step(); step();
      reserve_valid = 1'b0;
      check("double_reserve", busy_vec, 64'h1 << 30);
      wb_valid = 1'b1; wb_addr = 6'd30;
      step();
      wb_valid = 1'b0;
      check("double_reserve_clr", busy_vec, 64'h0);

      // Skip ineligible: move pointer 2 -> 0, block reg 3
      req_valid = 3'b100; set_addr(2, 6'd0);
      reserve_valid = 1'b1; reserve_addr = 6'd3;
      #1;
      check("skip_pre_ready", 64'(req_ready), 64'h4);
      step();
      reserve_valid = 1'b0;
      req_valid = 3'b011; set_addr(0, 6'd3); set_addr(1, 6'd4);
      #1;
      check("skip_ready", 64'(req_ready), 64'h2);
      check("skip_rd_addr", 64'(rf_rd_addr), 64'd4);
      step();
      req_valid = 3'b001;
      #1;
      check("skip_req0_waits", 64'(req_ready), 64'h0);
      req_valid = 3'b111; set_addr(1, 6'd8); set_addr(2, 6'd7);
      #1;
      check("skip_ptr_is_2", 64'(req_ready), 64'h4);
      step();
      req_valid = '0;
      wb_valid = 1'b1; wb_addr = 6'd3;
      step();
      wb_valid = 1'b0;
      check("skip_busy_clr", busy_vec, 64'h0);
      // pointer is now 0

      // Read and reserve of the same register in one cycle
      req_valid = 3'b001; set_addr(0, 6'd40); rf_rd_data = 64'h40;
      reserve_valid = 1'b1; reserve_addr = 6'd40;
      #1;
      check("rdres_ready", 64'(req_ready), 64'h1);
      step();
      req_valid = '0; reserve_valid = 1'b0;
      check("rdres_resp_data", resp_data, 64'h40);
      check("rdres_busy", busy_vec, 64'h1 << 40);
      // pointer is now 1

      // Reset mid-flight
      reserve_valid = 1'b1; reserve_addr = 6'd50;
      req_valid = 3'b111; set_addr(0, 6'd1); set_addr(1, 6'd2); set_addr(2, 6'd5);
      rf_rd_data = 64'h77;
      #1;
      check("mid_grant", 64'(req_ready), 64'h2);
      step();
      reserve_valid = 1'b0;
      reset = 1'b1;
      check("mid_resp_before_rst", 64'(resp_valid), 64'h2);
      #1;
      check("mid_rst_ready", 64'(req_ready), 64'h0);
      step();
      reset = 1'b0;
      check("mid_resp_dropped", 64'(resp_valid), 64'h0);
      check("mid_busy_cleared", busy_vec, 64'h0);
      #1;
      check("mid_ptr_zero", 64'(req_ready), 64'h1);
      step();
      req_valid = '0;
      check("mid_after_resp", 64'(resp_valid), 64'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
